eth_rx_frame_buffer: RTL and testbench
======================================

Name: eth_rx_frame_buffer

Overview:
- Sits directly downstream of the 1G RGMII MAC receive FIFO.
- Consumes its byte-wide rx_axis stream, which has no backpressure (tready is tied high upstream).
- Filters frames on destination MAC, packs bytes little-endian into 32-bit words and writes them into a two-slot ping-pong packet RAM.
- Publishes per-frame length/slot status for software, which releases each slot after reading it.

Parameters:
- BUF_ADDR_WIDTH, 9, word-address width per slot (2^(BUF_ADDR_WIDTH+2) bytes per slot = 2048).
- LEN_WIDTH, 12, width of the byte-length field; must be >= BUF_ADDR_WIDTH+3.

Ports:
- clk  in  1  system clock, 125 MHz logic clock shared with the MAC.
- rst_n  in  1  asynchronous active-low reset.
- rx_axis_tdata  in  8  received byte.
- rx_axis_tvalid  in  1  byte valid; always accepted.
- rx_axis_tlast  in  1  last byte of frame.
- rx_axis_tuser  in  1  bad-frame flag; meaningful on any beat.
- mac_addr  in  48  station address; byte 0 is the first on the wire and sits in bits [47:40].
- promisc  in  1  accept all destinations.
- buf_wr_en  out  1  RAM write strobe.
- buf_wr_addr  out  BUF_ADDR_WIDTH+1  {slot, word index}.
- buf_wr_data  out  32  packed word; byte n of the frame goes to lane n%4.
- buf_wr_be  out  4  lane byte enables.
- buf_release  in  2  one-cycle pulse per slot; software frees that slot.
- buf_full  out  2  slot holds a committed frame.
- frame_done  out  1  one-cycle commit pulse.
- frame_slot  out  1  slot of the last committed frame.
- frame_len  out  LEN_WIDTH  byte count of the last committed frame.
- drop_count  out  16  saturating count of dropped frames.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, next slot = 0. Assertion mid-frame abandons the frame with no commit and no count.
- IDLE:
  - On a valid beat, if a slot is free, choose it: prefer the next slot, otherwise the other one. Go to HDR with byte count = 1.
  - If both slots are full, go to DROP.
  - If the first beat also has tlast, the frame is runt: drop and stay in IDLE.
- HDR: compare bytes 0..5 against mac_addr, against broadcast (all 0xFF), and collect the multicast bit (byte0[0]).
  - tlast before byte 5 → runt → drop.
  - After byte 5: accept if promisc, or unicast match, or broadcast. Non-matching unicast and non-broadcast multicast → DROP.
  - Otherwise go to BODY.
- BODY:
  - Bytes accumulate in a 32-bit shift register.
  - A word write is issued on the cycle after the 4th byte of a word, or after tlast with partial buf_wr_be (e.g. 4'b0011 for 2 residual bytes).
  - Header bytes are written the same way as body bytes.
  - Byte count reaching 2^(BUF_ADDR_WIDTH+2) without tlast → overflow → DROP.
- DROP: ignore beats until a beat with tlast, then return to IDLE and increment drop_count, saturating at 0xFFFF.
- Error latch: tuser on any beat sets an error latch, and the frame is dropped at tlast. A frame dropped after writes started leaves slot contents undefined and buf_full unchanged.
- Commit: on a good tlast, one cycle after the final word write:
  - frame_done = 1 for one cycle.
  - frame_len = byte count including FCS; frame_slot = slot.
  - buf_full[slot] set.
  - next slot = ~slot.
- Release:
  - buf_release[i] clears buf_full[i] on the next edge.
  - Release of a non-full slot is a no-op.
  - A commit to a slot and its release cannot coincide, since commits only target free slots.
  - A release and a new-frame start on the same cycle: the slot is not yet free for that frame.
- Back-to-back frames (tlast followed immediately by tvalid) must be handled without losing a beat. The IDLE decision uses registered buf_full.

Decomposition:
- Package eth_rx_buf_pkg:
  - FSM state enum (IDLE, HDR, BODY, DROP).
  - ETH_ADDR_LEN=6, BCAST_ADDR=48'hFFFF_FFFF_FFFF.
  - Runt threshold constant.
- Sub-module eth_rx_dest_filter:
  - Byte-serial 6-byte destination comparator.
  - Outputs match, bcast, mcast and done.

Test Plan:
- 64-byte unicast frame to mac_addr=02:00:00:00:00:01 into an empty buffer → 16 writes to slot 0 with be=4'hF; frame_done with frame_len=64, frame_slot=0; buf_full=2'b01.
- 61-byte broadcast frame → final write be=4'b0001; frame_len=61.
- Unicast to 02:00:00:00:00:02 with promisc=0 → no frame_done, drop_count=1; repeat with promisc=1 → accepted.
- Three back-to-back good frames with no release → slots 0 and 1 fill, third dropped, drop_count=1. buf_release=2'b01, then a fourth frame → lands in slot 0.
- tuser asserted on byte 30 of a 100-byte frame → no commit, buf_full unchanged, drop_count increments. A 3-byte frame with tlast → runt drop.
- 2100-byte frame → overflow drop at byte 2048. rst_n pulsed mid-frame → all outputs 0; the next clean frame commits to slot 0.

Source files
------------

// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared types and constants for the Ethernet receive frame buffer.
package eth_rx_buf_pkg;

    localparam int unsigned ETH_ADDR_LEN   = 6;
    localparam logic [47:0] BCAST_ADDR     = 48'hFFFF_FFFF_FFFF;
    // A frame must carry at least one byte past the destination address
    localparam int unsigned RUNT_MIN_BYTES = ETH_ADDR_LEN + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_DROP
    } rx_state_t;

    // One beat of the byte-wide receive stream
    typedef struct packed {
        logic [7:0] tdata;
        logic       tlast;
        logic       tuser;
    } rx_beat_t;

endpackage

// File: rtl/eth_rx_frame_buffer_if.sv
// Byte-wide receive stream from the MAC FIFO (no backpressure).
interface eth_rx_frame_buffer_if;
    import eth_rx_buf_pkg::*;

    rx_beat_t beat;
    logic     tvalid;

    modport master (output beat, output tvalid);
    modport slave  (input  beat, input  tvalid);

endinterface

// File: rtl/eth_rx_frame_buffer_dest_filter.sv
// Byte-serial comparator for the 6-byte destination MAC address.
module eth_rx_dest_filter
    import eth_rx_buf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [2:0]  i_idx,
    input  logic [7:0]  i_data,
    input  logic [47:0] i_mac,
    output logic        o_match_c,
    output logic        o_bcast_c,
    output logic        o_mcast_c,
    output logic        o_done_c
);

    logic       r_match;
    logic       r_bcast;
    logic       r_mcast;
    logic [7:0] w_mac_byte;
    logic [7:0] w_bc_byte;
    logic       w_first;

    // Pick the reference bytes for the current header position
    always_comb begin
        w_mac_byte = '0;
        w_bc_byte  = '0;
        for (int k = 0; k < ETH_ADDR_LEN; k++) begin
            if (i_idx == 3'(k)) begin
                w_mac_byte = i_mac[8*(ETH_ADDR_LEN-1-k) +: 8];
                w_bc_byte  = BCAST_ADDR[8*(ETH_ADDR_LEN-1-k) +: 8];
            end
        end
    end

    assign w_first   = (i_idx == 3'd0);
    assign o_match_c = (w_first | r_match) & (i_data == w_mac_byte);
    assign o_bcast_c = (w_first | r_bcast) & (i_data == w_bc_byte);
    assign o_mcast_c = w_first ? i_data[0] : r_mcast;
    assign o_done_c  = i_valid & (i_idx == 3'(ETH_ADDR_LEN - 1));

    // Accumulate per-byte comparison results across the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
            r_bcast <= 1'b0;
            r_mcast <= 1'b0;
        end else if (i_valid) begin
            r_match <= o_match_c;
            r_bcast <= o_bcast_c;
            r_mcast <= o_mcast_c;
        end
    end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Filters received frames by destination, packs them into a ping-pong packet RAM
// and publishes per-slot status for software.
module eth_rx_frame_buffer
    import eth_rx_buf_pkg::*;
#(
    parameter int unsigned BUF_ADDR_WIDTH = 9,
    parameter int unsigned LEN_WIDTH      = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    eth_rx_frame_buffer_if.slave      i_rx,
    input  logic [47:0]               i_mac_addr,
    input  logic                      i_promisc,
    output logic                      o_buf_wr_en,
    output logic [BUF_ADDR_WIDTH:0]   o_buf_wr_addr,
    output logic [31:0]               o_buf_wr_data,
    output logic [3:0]                o_buf_wr_be,
    input  logic [1:0]                i_buf_release,
    output logic [1:0]                o_buf_full,
    output logic                      o_frame_done,
    output logic                      o_frame_slot,
    output logic [LEN_WIDTH-1:0]      o_frame_len,
    output logic [15:0]               o_drop_count
);

    localparam int unsigned SLOT_BYTES = 1 << (BUF_ADDR_WIDTH + 2);

    rx_state_t                 r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]      r_cnt, w_cnt_nxt, w_pos;
    logic [1:0]                w_lane;
    logic [BUF_ADDR_WIDTH-1:0] w_word_idx;
    logic [31:0]               r_word, w_word;
    logic [3:0]                w_be;
    logic                      r_slot, w_slot_nxt, r_next_slot;
    logic                      r_err, w_err_nxt, w_err_now;
    logic [1:0]                r_full, w_full_eff;
    logic                      w_pref, w_accept;
    logic                      w_store, w_wr, w_drop_inc, w_commit, r_commit_pend;
    logic                      w_match, w_bcast, w_mcast, w_hdr_done;

    logic                      r_wr_en;
    logic [BUF_ADDR_WIDTH:0]   r_wr_addr;
    logic [31:0]               r_wr_data;
    logic [3:0]                r_wr_be;
    logic                      r_frame_done;
    logic                      r_frame_slot;
    logic [LEN_WIDTH-1:0]      r_frame_len;
    logic [15:0]               r_drop_count;

    assign w_pos      = (r_state == ST_IDLE) ? '0 : r_cnt;
    assign w_lane     = w_pos[1:0];
    assign w_word_idx = w_pos[BUF_ADDR_WIDTH+1:2];
    assign w_be       = i_rx.beat.tlast ? 4'(4'hF >> (2'd3 - w_lane)) : 4'hF;
    assign w_err_now  = r_err | i_rx.beat.tuser;

    // A frame awaiting commit already owns its slot for the next slot decision
    assign w_full_eff = r_full | (r_commit_pend ? 2'(2'b01 << r_slot) : 2'b00);
    assign w_pref     = r_commit_pend ? ~r_slot : r_next_slot;
    assign w_accept   = i_promisc | w_bcast | (w_match & ~w_mcast);

    eth_rx_dest_filter u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_rx.tvalid & ((r_state == ST_IDLE) | (r_state == ST_HDR))),
        .i_idx     (w_pos[2:0]),
        .i_data    (i_rx.beat.tdata),
        .i_mac     (i_mac_addr),
        .o_match_c (w_match),
        .o_bcast_c (w_bcast),
        .o_mcast_c (w_mcast),
        .o_done_c  (w_hdr_done)
    );

    // Merge the incoming byte into its little-endian lane
    always_comb begin
        w_word = r_word;
        w_word[8*w_lane +: 8] = i_rx.beat.tdata;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state, slot choice, write/commit/drop decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_slot_nxt  = r_slot;
        w_err_nxt   = r_err;
        w_store     = 1'b0;
        w_wr        = 1'b0;
        w_drop_inc  = 1'b0;
        w_commit    = 1'b0;
        if (i_rx.tvalid) begin
            w_cnt_nxt = w_pos + LEN_WIDTH'(1);
            w_err_nxt = w_err_now;
            case (r_state)
                ST_IDLE: begin
                    w_err_nxt = i_rx.beat.tuser;
                    w_store   = 1'b1;
                    if (i_rx.beat.tlast) begin
                        w_drop_inc = 1'b1;
                    end else if (!w_full_eff[w_pref]) begin
                        w_slot_nxt  = w_pref;
                        w_state_nxt = ST_HDR;
                    end else if (!w_full_eff[~w_pref]) begin
                        w_slot_nxt  = ~w_pref;
                        w_state_nxt = ST_HDR;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end
                ST_HDR: begin
                    w_store = 1'b1;
                    if (i_rx.beat.tlast) begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_wr = (w_lane == 2'd3);
                        if (w_hdr_done) w_state_nxt = w_accept ? ST_BODY : ST_DROP;
                    end
                end
                ST_BODY: begin
                    w_store = 1'b1;
                    w_wr    = (w_lane == 2'd3) | i_rx.beat.tlast;
                    if (i_rx.beat.tlast) begin
                        w_state_nxt = ST_IDLE;
                        if (w_err_now) w_drop_inc = 1'b1;
                        else           w_commit   = 1'b1;
                    end else if (w_pos == LEN_WIDTH'(SLOT_BYTES - 1)) begin
                        w_state_nxt = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (i_rx.beat.tlast) begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Frame datapath and RAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_slot    <= 1'b0;
            r_err     <= 1'b0;
            r_word    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_be   <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_slot  <= w_slot_nxt;
            r_err   <= w_err_nxt;
            r_wr_en <= w_wr;
            if (w_store) r_word <= w_word;
            if (w_wr) begin
                r_wr_addr <= {r_slot, w_word_idx};
                r_wr_data <= w_word;
                r_wr_be   <= w_be;
            end
        end
    end

    // Commit one cycle after the final write, slot ownership, drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_pend <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_slot  <= 1'b0;
            r_frame_len   <= '0;
            r_next_slot   <= 1'b0;
            r_full        <= '0;
            r_drop_count  <= '0;
        end else begin
            r_commit_pend <= w_commit;
            r_frame_done  <= r_commit_pend;
            r_full        <= (r_full & ~i_buf_release) |
                             (r_commit_pend ? 2'(2'b01 << r_slot) : 2'b00);
            if (r_commit_pend) begin
                r_frame_slot <= r_slot;
                r_frame_len  <= r_cnt;
                r_next_slot  <= ~r_slot;
            end
            if (w_drop_inc && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_buf_wr_en   = r_wr_en;
    assign o_buf_wr_addr = r_wr_addr;
    assign o_buf_wr_data = r_wr_data;
    assign o_buf_wr_be   = r_wr_be;
    assign o_buf_full    = r_full;
    assign o_frame_done  = r_frame_done;
    assign o_frame_slot  = r_frame_slot;
    assign o_frame_len   = r_frame_len;
    assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Scoreboard bench for eth_rx_frame_buffer: directed frames, queued expectations.
module tb_eth_rx_frame_buffer;
    import eth_rx_buf_pkg::*;

    localparam int unsigned AW = 9;
    localparam int unsigned LW = 12;
    localparam logic [47:0] MAC_OWN   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;

    typedef struct packed {
        logic [AW:0]  addr;
        logic [31:0]  data;
        logic [3:0]   be;
    } wr_exp_t;

    typedef struct packed {
        logic          slot;
        logic [LW-1:0] len;
    } cm_exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [47:0]   mac_addr;
    logic          promisc;
    logic          buf_wr_en;
    logic [AW:0]   buf_wr_addr;
    logic [31:0]   buf_wr_data;
    logic [3:0]    buf_wr_be;
    logic [1:0]    buf_release;
    logic [1:0]    buf_full;
    logic          frame_done;
    logic          frame_slot;
    logic [LW-1:0] frame_len;
    logic [15:0]   drop_count;

    wr_exp_t exp_wr[$];
    cm_exp_t exp_cm[$];
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      last_wr_cyc = -10;
    logic    drop_window = 1'b0;

    eth_rx_frame_buffer_if u_rx ();

    eth_rx_frame_buffer u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx          (u_rx),
        .i_mac_addr    (mac_addr),
        .i_promisc     (promisc),
        .o_buf_wr_en   (buf_wr_en),
        .o_buf_wr_addr (buf_wr_addr),
        .o_buf_wr_data (buf_wr_data),
        .o_buf_wr_be   (buf_wr_be),
        .i_buf_release (buf_release),
        .o_buf_full    (buf_full),
        .o_frame_done  (frame_done),
        .o_frame_slot  (frame_slot),
        .o_frame_len   (frame_len),
        .o_drop_count  (drop_count)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int i, input logic [47:0] dst);
        if (i < ETH_ADDR_LEN) return dst[8*(ETH_ADDR_LEN-1-i) +: 8];
        return 8'(i * 13 + 5);
    endfunction

    // Monitor: pop and compare whenever the DUT writes or commits
    always @(negedge clk) begin
        if (rst_n) begin
            if (buf_wr_en && !drop_window) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=0x%0h be=0x%0h", buf_wr_addr, buf_wr_be);
                end else begin
                    wr_exp_t e;
                    logic [31:0] mask;
                    e = exp_wr.pop_front();
                    mask = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
                    check("wr_addr", 64'(buf_wr_addr), 64'(e.addr));
                    check("wr_be", 64'(buf_wr_be), 64'(e.be));
                    check("wr_data", 64'(buf_wr_data & mask), 64'(e.data));
                    last_wr_cyc = cyc;
                end
            end
            if (frame_done) begin
                if (exp_cm.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_commit slot=%0d len=%0d", frame_slot, frame_len);
                end else begin
                    cm_exp_t c;
                    c = exp_cm.pop_front();
                    check("frame_slot", 64'(frame_slot), 64'(c.slot));
                    check("frame_len", 64'(frame_len), 64'(c.len));
                    check("commit_latency", 64'(cyc - last_wr_cyc), 64'd1);
                end
            end
        end
    end

    // Drive one frame; expectations are queued first when it should be accepted
    task automatic send_frame(input int len, input logic [47:0] dst, input int err_at, input int exp_slot);
        logic [31:0] w;
        logic [3:0]  be;
        if (exp_slot >= 0) begin
            w  = '0;
            be = '0;
            for (int i = 0; i < len; i++) begin
                w[8*(i%4) +: 8] = frame_byte(i, dst);
                be[i%4] = 1'b1;
                if ((i % 4 == 3) || (i == len - 1)) begin
                    exp_wr.push_back('{addr: {1'(exp_slot), AW'(i / 4)}, data: w, be: be});
                    w  = '0;
                    be = '0;
                end
            end
            exp_cm.push_back('{slot: 1'(exp_slot), len: LW'(len)});
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            u_rx.tvalid = 1'b1;
            u_rx.beat   = '{tdata: frame_byte(i, dst), tlast: (i == len - 1), tuser: (i == err_at)};
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        u_rx.tvalid = 1'b0;
        u_rx.beat   = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        idle(4);
        drop_window = 1'b0;
    endtask

    task automatic release_slots(input logic [1:0] v);
        @(negedge clk);
        buf_release = v;
        @(negedge clk);
        buf_release = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        u_rx.tvalid = 1'b0;
        u_rx.beat   = '0;
        mac_addr    = MAC_OWN;
        promisc     = 1'b0;
        buf_release = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 64'(buf_wr_en), 64'd0);
        check("rst_full", 64'(buf_full), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_slot", 64'(frame_slot), 64'd0);
        check("rst_len", 64'(frame_len), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 64-byte unicast into empty buffer
        send_frame(64, MAC_OWN, -1, 0);
        idle(4);
        check("full_after_f1", 64'(buf_full), 64'b01);
        check("drops_after_f1", 64'(drop_count), 64'd0);

        // 61-byte broadcast, residual be 0001
        send_frame(61, BCAST_ADDR, -1, 1);
        idle(4);
        check("full_after_bcast", 64'(buf_full), 64'b11);
        release_slots(2'b11);
        check("full_after_rel11", 64'(buf_full), 64'b00);

        // Foreign unicast: dropped, then accepted under promisc
        drop_window = 1'b1;
        send_frame(64, MAC_OTHER, -1, -1);
        settle();
        check("drops_foreign", 64'(drop_count), 64'd1);
        check("full_foreign", 64'(buf_full), 64'b00);
        promisc = 1'b1;
        send_frame(64, MAC_OTHER, -1, 0);
        idle(4);
        promisc = 1'b0;
        check("full_promisc", 64'(buf_full), 64'b01);
        release_slots(2'b01);
        check("full_after_rel01", 64'(buf_full), 64'b00);

        // Three back-to-back frames: next slot is 1, then 0, third dropped
        send_frame(60, MAC_OWN, -1, 1);
        send_frame(72, MAC_OWN, -1, 0);
        send_frame(64, MAC_OWN, -1, -1);
        idle(4);
        check("full_b2b", 64'(buf_full), 64'b11);
        check("drops_b2b", 64'(drop_count), 64'd2);
        release_slots(2'b01);
        check("full_after_rel_s0", 64'(buf_full), 64'b10);
        send_frame(70, MAC_OWN, -1, 0);
        idle(4);
        check("full_fourth", 64'(buf_full), 64'b11);
        release_slots(2'b11);
        check("full_all_released", 64'(buf_full), 64'b00);

        // tuser on byte 30 of a 100-byte frame
        drop_window = 1'b1;
        send_frame(100, MAC_OWN, 30, -1);
        settle();
        check("drops_tuser", 64'(drop_count), 64'd3);
        check("full_tuser", 64'(buf_full), 64'b00);

        // 3-byte runt
        drop_window = 1'b1;
        send_frame(3, MAC_OWN, -1, -1);
        settle();
        check("drops_runt", 64'(drop_count), 64'd4);

        // 2100-byte frame overflows the slot
        drop_window = 1'b1;
        send_frame(2100, MAC_OWN, -1, -1);
        settle();
        check("drops_overflow", 64'(drop_count), 64'd5);
        check("full_overflow", 64'(buf_full), 64'b00);

        // Reset in the middle of a frame
        drop_window = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            u_rx.tvalid = 1'b1;
            u_rx.beat   = '{tdata: frame_byte(i, MAC_OWN), tlast: 1'b0, tuser: 1'b0};
        end
        @(negedge clk);
        rst_n       = 1'b0;
        u_rx.tvalid = 1'b0;
        u_rx.beat   = '0;
        @(negedge clk);
        check("mid_rst_wr_en", 64'(buf_wr_en), 64'd0);
        check("mid_rst_addr", 64'(buf_wr_addr), 64'd0);
        check("mid_rst_data", 64'(buf_wr_data), 64'd0);
        check("mid_rst_be", 64'(buf_wr_be), 64'd0);
        check("mid_rst_drops", 64'(drop_count), 64'd0);
        check("mid_rst_len", 64'(frame_len), 64'd0);
        rst_n = 1'b1;
        settle();
        send_frame(64, MAC_OWN, -1, 0);
        idle(4);
        check("full_after_reset", 64'(buf_full), 64'b01);
        check("drops_after_reset", 64'(drop_count), 64'd0);

        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        check("pending_commits", 64'(exp_cm.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
